// File: rtl/pio_input_irq_pkg.sv
// Shared register addresses, edge-mode encodings and sizing helper for the
// pio_input_irq block.
package pio_input_irq_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // The debounce counter needs at least one bit, even when filtering is off.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and accepted value,
// with single-cycle pulses marking the cycle the accepted value changes.
module pio_debounce_bit
  import pio_input_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int N     = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic             sync1_q, s_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs; that is what keeps sync1_q -> s_q a real two-stage chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_i;
      s_q      <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch can be inferred.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s_q;
      cnt_d    = '0;
      accept   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = accept & s_q;
  assign fall_o   = accept & ~s_q;

endmodule

// File: rtl/pio_input_irq.sv
// Avalon-MM input PIO: debounced inputs, edge capture with write-1-to-clear,
// per-bit interrupt mask and a registered level interrupt.
module pio_input_irq
  import pio_input_irq_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE       = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_w, rise_w, fall_w, edge_hit;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_i     (in_port[i]),
      .stable_o (stable_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i])
    );
  end

  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    if (EDGE_MODE == EDGE_FALLING)  edge_hit = fall_w;
    else if (EDGE_MODE == EDGE_ANY) edge_hit = rise_w | fall_w;
    else                            edge_hit = rise_w;
  end

  // The clear is applied before the new edges are OR-ed in, so an edge that
  // arrives with a W1C on the same bit survives.
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE) edge_d = edge_q & ~writedata[WIDTH-1:0];
    edge_d = edge_d | edge_hit;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = stable_w;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      default:   readdata_d = '0;
    endcase
    irq_d = |(edge_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_input_irq.sv
// Directed bench for pio_input_irq: five configurations share the bus and are
// checked through an expected-value queue.
module tb_pio_input_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [4:0]  cs;

  logic [3:0]  in8, in4, in_f, in_a;
  logic [31:0] in_w;
  logic [31:0] rd8, rd4, rd_f, rd_a, rd_w;
  logic        irq8, irq4, irq_f, irq_a, irq_w;

  localparam int S8 = 0, S4 = 1, SF = 2, SA = 3, SW = 4;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  pio_input_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_MODE(0)) u8 (
    .clk(clk), .reset_n(reset_n), .in_port(in8), .address(address),
    .chipselect(cs[S8]), .write_n(write_n), .writedata(writedata),
    .readdata(rd8), .irq(irq8));

  pio_input_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u4 (
    .clk(clk), .reset_n(reset_n), .in_port(in4), .address(address),
    .chipselect(cs[S4]), .write_n(write_n), .writedata(writedata),
    .readdata(rd4), .irq(irq4));

  pio_input_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_MODE(1)) u_f (
    .clk(clk), .reset_n(reset_n), .in_port(in_f), .address(address),
    .chipselect(cs[SF]), .write_n(write_n), .writedata(writedata),
    .readdata(rd_f), .irq(irq_f));

  pio_input_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .EDGE_MODE(2)) u_a (
    .clk(clk), .reset_n(reset_n), .in_port(in_a), .address(address),
    .chipselect(cs[SA]), .write_n(write_n), .writedata(writedata),
    .readdata(rd_a), .irq(irq_a));

  pio_input_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)) u_w (
    .clk(clk), .reset_n(reset_n), .in_port(in_w), .address(address),
    .chipselect(cs[SW]), .write_n(write_n), .writedata(writedata),
    .readdata(rd_w), .irq(irq_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // One write cycle to the selected slave; it takes effect on the next edge.
  task automatic bus_write(input int sel, input logic [1:0] addr, input logic [31:0] data);
    cs        = 5'b0;
    cs[sel]   = 1'b1;
    write_n   = 1'b0;
    address   = addr;
    writedata = data;
    tick(1);
    cs        = 5'b0;
    write_n   = 1'b1;
    writedata = '0;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = '0; cs = 5'b0;
    in8 = '0; in4 = '0; in_f = '0; in_a = '0; in_w = '0;
    tick(3);
    reset_n = 1'b1;

    // Debounce reject: a 5-cycle pulse never reaches N=8.
    address = 2'd3;
    in8 = 4'h1;
    tick(5);
    in8 = 4'h0;
    expect_val("reject_edge", 32'h0);
    expect_val("reject_irq", 32'h0);
    tick(20);
    sb_check(rd8);
    sb_check({31'b0, irq8});
    address = 2'd0;
    expect_val("reject_data", 32'h0);
    tick(1);
    sb_check(rd8);

    // Debounce accept on bit 2: EDGE_CAP set at edge 10, visible at edge 11.
    address = 2'd3;
    tick(2);
    in8 = 4'h4;
    expect_val("accept_edge_e10", 32'h0);
    tick(10);
    sb_check(rd8);
    expect_val("accept_edge_e11", 32'h4);
    expect_val("accept_irq_masked", 32'h0);
    tick(1);
    sb_check(rd8);
    sb_check({31'b0, irq8});
    expect_val("mask_irq_edge1", 32'h0);
    bus_write(S8, 2'd1, 32'h4);
    sb_check({31'b0, irq8});
    expect_val("mask_irq_edge2", 32'h1);
    tick(1);
    sb_check({31'b0, irq8});

    // W1C on bit 0 lands on the edge where bit 0's rise is accepted.
    address = 2'd3;
    in8 = 4'h5;
    tick(9);
    bus_write(S8, 2'd3, 32'h1);
    expect_val("race_edge", 32'h5);
    expect_val("race_irq", 32'h1);
    tick(1);
    sb_check(rd8);
    sb_check({31'b0, irq8});
    bus_write(S8, 2'd3, 32'h1);
    expect_val("w1c_bit0", 32'h4);
    tick(1);
    sb_check(rd8);
    bus_write(S8, 2'd3, 32'h4);
    expect_val("w1c_all", 32'h0);
    expect_val("w1c_irq_drop", 32'h0);
    tick(1);
    sb_check(rd8);
    sb_check({31'b0, irq8});
    bus_write(S8, 2'd1, 32'hFFFF_FFFF);
    expect_val("mask_readback", 32'h0000_000F);
    tick(1);
    sb_check(rd8);

    // Reset mid-operation on the N=4 instance.
    in4 = 4'hF;
    address = 2'd0;
    bus_write(S4, 2'd1, 32'hF);
    address = 2'd0;
    expect_val("pre_reset_data", 32'hF);
    expect_val("pre_reset_irq", 32'h1);
    tick(8);
    sb_check(rd4);
    sb_check({31'b0, irq4});
    #2 reset_n = 1'b0;
    expect_val("reset_readdata", 32'h0);
    expect_val("reset_irq", 32'h0);
    #1;
    sb_check(rd4);
    sb_check({31'b0, irq4});
    tick(1);
    reset_n = 1'b1;
    expect_val("post_reset_e6", 32'h0);
    tick(6);
    sb_check(rd4);
    expect_val("post_reset_data_e7", 32'hF);
    tick(1);
    sb_check(rd4);
    address = 2'd3;
    expect_val("post_reset_edge", 32'hF);
    expect_val("post_reset_irq", 32'h0);
    tick(1);
    sb_check(rd4);
    sb_check({31'b0, irq4});

    // Falling and any-edge modes on bit 1.
    in_f = 4'h2;
    in_a = 4'h2;
    expect_val("fall_rise_ignored", 32'h0);
    expect_val("any_rise", 32'h2);
    tick(6);
    sb_check(rd_f);
    sb_check(rd_a);
    bus_write(SA, 2'd3, 32'h2);
    expect_val("any_cleared", 32'h0);
    tick(1);
    sb_check(rd_a);
    in_f = 4'h0;
    in_a = 4'h0;
    expect_val("fall_fall", 32'h2);
    expect_val("any_fall", 32'h2);
    tick(6);
    sb_check(rd_f);
    sb_check(rd_a);

    // Full 32-bit width and the reserved address.
    in_w = 32'hA5A5_0F0F;
    address = 2'd0;
    expect_val("w32_data", 32'hA5A5_0F0F);
    tick(5);
    sb_check(rd_w);
    bus_write(SW, 2'd2, 32'hFFFF_FFFF);
    expect_val("w32_rsvd", 32'h0);
    tick(1);
    sb_check(rd_w);
    address = 2'd3;
    expect_val("w32_edge", 32'hA5A5_0F0F);
    tick(1);
    sb_check(rd_w);

    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
